// File: rtl/tpu_cmd_scheduler.sv
// Host-to-control-unit command scheduler: wrap-around FIFO, IDLE/ISSUE/RUN issue FSM, sticky irq.
// Optional RUN-cycle performance counter built only when TPU_SCHED_PERF_EN is defined.
module tpu_cmd_scheduler #(
   parameter int QUEUE_DEPTH = 4,
   parameter int CMD_WIDTH   = 64
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           host_cmd_valid,
   input  logic [CMD_WIDTH-1:0]           host_cmd_data,
   output logic                           host_cmd_ready,
   output logic                           cu_cmd_valid,
   output logic [CMD_WIDTH-1:0]           cu_cmd_data,
   input  logic                           cu_cmd_ready,
   input  logic                           cu_done_irq,
   input  logic                           irq_clear,
   output logic                           irq_out,
   output logic [$clog2(QUEUE_DEPTH):0]   queue_level,
   output logic [15:0]                    completed_count,
   output logic                           sched_busy,
   output logic [31:0]                    perf_run_cycles
);

   localparam int PW = $clog2(QUEUE_DEPTH);
   localparam int LW = PW + 1;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_RUN   = 2'd2
   } state_e;

   state_e               state_q, state_d;
   logic [CMD_WIDTH-1:0] mem_q [QUEUE_DEPTH];
   logic [PW-1:0]        wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]        rd_ptr_q, rd_ptr_d;
   logic [LW-1:0]        count_q, count_d;
   logic [15:0]          completed_q, completed_d;
   logic                 irq_q, irq_d;
   logic                 push_s, pop_s, done_s;
   logic                 cu_cmd_valid_s, sched_busy_s;

   assign host_cmd_ready = (count_q != LW'(QUEUE_DEPTH));
   assign push_s         = host_cmd_valid && host_cmd_ready;
   assign pop_s          = (state_q == ST_ISSUE) && cu_cmd_ready && (count_q != '0);
   assign done_s         = (state_q == ST_RUN) && cu_done_irq;

   // FIFO pointer / occupancy next-state; power-of-two depth lets pointers wrap naturally
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push_s) begin
         wr_ptr_d = wr_ptr_q + PW'(1);
      end else begin
         wr_ptr_d = wr_ptr_q;
      end
      if (pop_s) begin
         rd_ptr_d = rd_ptr_q + PW'(1);
      end else begin
         rd_ptr_d = rd_ptr_q;
      end
      case ({push_s, pop_s})
         2'b10:   count_d = count_q + LW'(1);
         2'b01:   count_d = count_q - LW'(1);
         default: count_d = count_q;
      endcase
   end

   // FIFO storage and occupancy registers
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < QUEUE_DEPTH; i++) begin
            mem_q[i] <= '0;
         end
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push_s) begin
            mem_q[wr_ptr_q] <= host_cmd_data;
         end
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // FSM state register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // FSM next state; leaving RUN looks at occupancy including a same-cycle push
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (count_q != '0) state_d = ST_ISSUE;
            else               state_d = ST_IDLE;
         end
         ST_ISSUE: begin
            if (pop_s) state_d = ST_RUN;
            else       state_d = ST_ISSUE;
         end
         ST_RUN: begin
            if (cu_done_irq) state_d = (count_d != '0) ? ST_ISSUE : ST_IDLE;
            else             state_d = ST_RUN;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // FSM outputs
   always_comb begin
      cu_cmd_valid_s = 1'b0;
      sched_busy_s   = (count_q != '0);
      case (state_q)
         ST_IDLE:  cu_cmd_valid_s = 1'b0;
         ST_ISSUE: begin
            cu_cmd_valid_s = 1'b1;
            sched_busy_s   = 1'b1;
         end
         ST_RUN:   sched_busy_s = 1'b1;
         default:  cu_cmd_valid_s = 1'b0;
      endcase
   end

   assign cu_cmd_valid = cu_cmd_valid_s;
   assign sched_busy   = sched_busy_s;
   assign cu_cmd_data  = (count_q != '0) ? mem_q[rd_ptr_q] : '0;
   assign queue_level  = count_q;

   // Completion counter and sticky irq; a new completion wins over a clear
   always_comb begin
      completed_d = completed_q;
      irq_d       = irq_q;
      if (done_s) begin
         completed_d = completed_q + 16'd1;
         irq_d       = 1'b1;
      end else if (irq_clear) begin
         irq_d       = 1'b0;
      end else begin
         irq_d       = irq_q;
      end
   end

   // Completion registers
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         completed_q <= 16'd0;
         irq_q       <= 1'b0;
      end else begin
         completed_q <= completed_d;
         irq_q       <= irq_d;
      end
   end

   assign completed_count = completed_q;
   assign irq_out         = irq_q;

`ifdef TPU_SCHED_PERF_EN
   logic [31:0] perf_q, perf_d;

   // Saturating RUN-cycle counter
   always_comb begin
      perf_d = perf_q;
      if ((state_q == ST_RUN) && (perf_q != 32'hFFFF_FFFF)) begin
         perf_d = perf_q + 32'd1;
      end else begin
         perf_d = perf_q;
      end
   end

   // Performance counter register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         perf_q <= 32'd0;
      end else begin
         perf_q <= perf_d;
      end
   end

   assign perf_run_cycles = perf_q;
`else
   assign perf_run_cycles = 32'd0;
`endif

endmodule

// File: tb/tb_tpu_cmd_scheduler.sv
// Self-checking bench for tpu_cmd_scheduler: vector table, directed corner sequences, random vs queue model.
module tb_tpu_cmd_scheduler;

   localparam int DEPTH = 4;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        host_cmd_valid = 1'b0;
   logic [63:0] host_cmd_data = 64'd0;
   logic        cu_cmd_ready = 1'b0;
   logic        cu_done_irq = 1'b0;
   logic        irq_clear = 1'b0;
   logic        host_cmd_ready, cu_cmd_valid, irq_out, sched_busy;
   logic [63:0] cu_cmd_data;
   logic [2:0]  queue_level;
   logic [15:0] completed_count;
   logic [31:0] perf_run_cycles;

   tpu_cmd_scheduler #(.QUEUE_DEPTH(DEPTH), .CMD_WIDTH(64)) dut (
      .clk(clk), .rst(rst),
      .host_cmd_valid(host_cmd_valid), .host_cmd_data(host_cmd_data), .host_cmd_ready(host_cmd_ready),
      .cu_cmd_valid(cu_cmd_valid), .cu_cmd_data(cu_cmd_data), .cu_cmd_ready(cu_cmd_ready),
      .cu_done_irq(cu_done_irq), .irq_clear(irq_clear), .irq_out(irq_out),
      .queue_level(queue_level), .completed_count(completed_count),
      .sched_busy(sched_busy), .perf_run_cycles(perf_run_cycles)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // Reference model: a queue of words plus which phase the scheduler is in.
   logic [63:0] mq[$];
   int          m_phase;   // 0 waiting for work, 1 offering head, 2 control unit busy
   int unsigned m_done;
   bit          m_irq;
   longint unsigned m_perf;

   task automatic model_reset();
      mq.delete();
      m_phase = 0;
      m_done  = 0;
      m_irq   = 1'b0;
      m_perf  = 0;
   endtask

   function automatic logic [63:0] exp_perf();
`ifdef TPU_SCHED_PERF_EN
      return m_perf;
`else
      return 64'd0;
`endif
   endfunction

   task automatic check_all(input string tag);
      chk({tag, "_valid"}, cu_cmd_valid, (m_phase == 1));
      chk({tag, "_data"},  cu_cmd_data, (mq.size() != 0) ? mq[0] : 64'd0);
      chk({tag, "_ready"}, host_cmd_ready, (mq.size() != DEPTH));
      chk({tag, "_level"}, queue_level, mq.size());
      chk({tag, "_count"}, completed_count, m_done & 32'hFFFF);
      chk({tag, "_irq"},   irq_out, m_irq);
      chk({tag, "_busy"},  sched_busy, (mq.size() != 0) || (m_phase != 0));
      chk({tag, "_perf"},  perf_run_cycles, exp_perf());
   endtask

   // One clock: drive inputs, advance the model, step the edge, compare.
   task automatic cyc(input bit hv, input logic [63:0] d, input bit cr, input bit dn, input bit cl,
                      input string tag = "m");
      bit push, pop, done_ev;
      int pre_size;
      host_cmd_valid = hv; host_cmd_data = d; cu_cmd_ready = cr; cu_done_irq = dn; irq_clear = cl;
      pre_size = mq.size();
      push     = hv && (pre_size != DEPTH);
      pop      = (m_phase == 1) && cr;
      done_ev  = (m_phase == 2) && dn;
      if (m_phase == 2 && m_perf < 64'hFFFF_FFFF) m_perf++;
      if (pop)  void'(mq.pop_front());
      if (push) mq.push_back(d);
      if (done_ev) begin
         m_done++;
         m_irq = 1'b1;
      end else if (cl) begin
         m_irq = 1'b0;
      end
      case (m_phase)
         0: if (pre_size != 0) m_phase = 1;
         1: if (pop) m_phase = 2;
         2: if (done_ev) m_phase = (mq.size() != 0) ? 1 : 0;
         default: m_phase = 0;
      endcase
      @(posedge clk);
      #1;
      check_all(tag);
   endtask

   task automatic do_reset(input string tag);
      host_cmd_valid = 1'b0; cu_cmd_ready = 1'b0; cu_done_irq = 1'b0; irq_clear = 1'b0;
      rst = 1'b0;
      #1;
      chk({tag, "_rst_level"}, queue_level, 64'd0);
      chk({tag, "_rst_valid"}, cu_cmd_valid, 64'd0);
      chk({tag, "_rst_data"},  cu_cmd_data, 64'd0);
      chk({tag, "_rst_irq"},   irq_out, 64'd0);
      chk({tag, "_rst_count"}, completed_count, 64'd0);
      chk({tag, "_rst_busy"},  sched_busy, 64'd0);
      chk({tag, "_rst_perf"},  perf_run_cycles, 64'd0);
      model_reset();
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
      chk({tag, "_rst_ready"}, host_cmd_ready, 64'd1);
   endtask

   typedef struct {
      bit hv; logic [63:0] d; bit cr; bit dn; bit cl;
      bit e_v; logic [63:0] e_d; int e_lvl; bit e_rdy; int e_cnt; bit e_irq; bit e_busy;
   } vec_t;

   vec_t tbl[13];
   logic [63:0] cmds[3];
   int tmo;

   initial begin
      // Single command, ignored early done, irq clear vs set, head stability
      tbl[0]  = '{1'b1, 64'h0123, 1'b1, 1'b0, 1'b0,  1'b0, 64'h0123, 1, 1'b1, 0, 1'b0, 1'b1};
      tbl[1]  = '{1'b0, 64'h0,    1'b1, 1'b0, 1'b0,  1'b1, 64'h0123, 1, 1'b1, 0, 1'b0, 1'b1};
      tbl[2]  = '{1'b0, 64'h0,    1'b1, 1'b0, 1'b0,  1'b0, 64'h0,    0, 1'b1, 0, 1'b0, 1'b1};
      tbl[3]  = '{1'b0, 64'h0,    1'b0, 1'b0, 1'b0,  1'b0, 64'h0,    0, 1'b1, 0, 1'b0, 1'b1};
      tbl[4]  = '{1'b0, 64'h0,    1'b0, 1'b1, 1'b0,  1'b0, 64'h0,    0, 1'b1, 1, 1'b1, 1'b0};
      tbl[5]  = '{1'b0, 64'h0,    1'b0, 1'b1, 1'b0,  1'b0, 64'h0,    0, 1'b1, 1, 1'b1, 1'b0};
      tbl[6]  = '{1'b0, 64'h0,    1'b0, 1'b0, 1'b1,  1'b0, 64'h0,    0, 1'b1, 1, 1'b0, 1'b0};
      tbl[7]  = '{1'b1, 64'hAA,   1'b0, 1'b0, 1'b0,  1'b0, 64'hAA,   1, 1'b1, 1, 1'b0, 1'b1};
      tbl[8]  = '{1'b0, 64'h0,    1'b0, 1'b0, 1'b0,  1'b1, 64'hAA,   1, 1'b1, 1, 1'b0, 1'b1};
      tbl[9]  = '{1'b1, 64'hBB,   1'b0, 1'b0, 1'b0,  1'b1, 64'hAA,   2, 1'b1, 1, 1'b0, 1'b1};
      tbl[10] = '{1'b0, 64'h0,    1'b1, 1'b1, 1'b0,  1'b0, 64'hBB,   1, 1'b1, 1, 1'b0, 1'b1};
      tbl[11] = '{1'b0, 64'h0,    1'b0, 1'b1, 1'b1,  1'b1, 64'hBB,   1, 1'b1, 2, 1'b1, 1'b1};
      tbl[12] = '{1'b0, 64'h0,    1'b0, 1'b0, 1'b1,  1'b1, 64'hBB,   1, 1'b1, 2, 1'b0, 1'b1};

      #2;
      do_reset("init");
      for (int i = 0; i < 13; i++) begin
         cyc(tbl[i].hv, tbl[i].d, tbl[i].cr, tbl[i].dn, tbl[i].cl, $sformatf("tbl%0d_m", i));
         chk($sformatf("tbl%0d_valid", i), cu_cmd_valid, tbl[i].e_v);
         chk($sformatf("tbl%0d_data", i),  cu_cmd_data, tbl[i].e_d);
         chk($sformatf("tbl%0d_level", i), queue_level, tbl[i].e_lvl);
         chk($sformatf("tbl%0d_ready", i), host_cmd_ready, tbl[i].e_rdy);
         chk($sformatf("tbl%0d_count", i), completed_count, tbl[i].e_cnt);
         chk($sformatf("tbl%0d_irq", i),   irq_out, tbl[i].e_irq);
         chk($sformatf("tbl%0d_busy", i),  sched_busy, tbl[i].e_busy);
      end

      // Fill: four accepted, fifth held until the first pop frees a slot
      do_reset("fill");
      for (int i = 0; i < 5; i++) begin
         cyc(1'b1, 64'hF000 + i, 1'b0, 1'b0, 1'b0, "fill_m");
         chk($sformatf("fill%0d_level", i), queue_level, (i < 4) ? i + 1 : 4);
         chk($sformatf("fill%0d_ready", i), host_cmd_ready, (i < 3));
      end
      cyc(1'b1, 64'hF004, 1'b1, 1'b0, 1'b0, "fill_pop_m");
      chk("fill_pop_level", queue_level, 64'd3);
      chk("fill_pop_ready", host_cmd_ready, 64'd1);
      cyc(1'b1, 64'hF004, 1'b0, 1'b0, 1'b0, "fill_push5_m");
      chk("fill_push5_level", queue_level, 64'd4);
      chk("fill_push5_head", cu_cmd_data, 64'hF001);
      cyc(1'b0, 64'h0, 1'b0, 1'b0, 1'b0, "fill_idle_m");

      // Back-to-back: three commands, each completing after 10 RUN cycles
      do_reset("b2b");
      cmds[0] = 64'hC0C0_0000_0000_0001;
      cmds[1] = 64'hC1C1_0000_0000_0002;
      cmds[2] = 64'hC2C2_0000_0000_0003;
      for (int k = 0; k < 3; k++) cyc(1'b1, cmds[k], 1'b0, 1'b0, 1'b0, "b2b_push_m");
      for (int k = 0; k < 3; k++) begin
         tmo = 0;
         while (!cu_cmd_valid && tmo < 20) begin
            cyc(1'b0, 64'h0, 1'b0, 1'b0, 1'b0, "b2b_wait_m");
            tmo++;
         end
         chk($sformatf("b2b%0d_valid", k), cu_cmd_valid, 64'd1);
         chk($sformatf("b2b%0d_order", k), cu_cmd_data, cmds[k]);
         cyc(1'b0, 64'h0, 1'b1, 1'b0, 1'b0, "b2b_hs_m");
         repeat (9) cyc(1'b0, 64'h0, 1'b0, 1'b0, 1'b0, "b2b_run_m");
         cyc(1'b0, 64'h0, 1'b0, 1'b1, 1'b0, "b2b_done_m");
         chk($sformatf("b2b%0d_direct", k), cu_cmd_valid, (k < 2));
      end
      chk("b2b_count", completed_count, 64'd3);
      chk("b2b_busy", sched_busy, 64'd0);

      // Reset while running with two queued: everything discarded, late done ignored
      do_reset("arst_pre");
      cyc(1'b1, 64'h55, 1'b1, 1'b0, 1'b0, "arst_m");
      cyc(1'b0, 64'h0,  1'b1, 1'b0, 1'b0, "arst_m");
      cyc(1'b0, 64'h0,  1'b1, 1'b0, 1'b0, "arst_m");
      cyc(1'b0, 64'h0,  1'b0, 1'b1, 1'b0, "arst_m");
      cyc(1'b1, 64'hA1, 1'b1, 1'b0, 1'b0, "arst_m");
      cyc(1'b1, 64'hB2, 1'b1, 1'b0, 1'b0, "arst_m");
      cyc(1'b1, 64'hC3, 1'b1, 1'b0, 1'b0, "arst_m");
      cyc(1'b0, 64'h0,  1'b0, 1'b0, 1'b0, "arst_m");
      chk("arst_pre_level", queue_level, 64'd2);
      chk("arst_pre_irq", irq_out, 64'd1);
      #2;
      do_reset("arst");
      cyc(1'b0, 64'h0, 1'b0, 1'b1, 1'b0, "arst_late_m");
      chk("arst_late_count", completed_count, 64'd0);
      chk("arst_late_irq", irq_out, 64'd0);

      // RUN held for 20 cycles
      do_reset("perf");
      cyc(1'b1, 64'h77, 1'b1, 1'b0, 1'b0, "perf_m");
      cyc(1'b0, 64'h0,  1'b1, 1'b0, 1'b0, "perf_m");
      cyc(1'b0, 64'h0,  1'b1, 1'b0, 1'b0, "perf_m");
      repeat (20) cyc(1'b0, 64'h0, 1'b0, 1'b0, 1'b0, "perf_m");
`ifdef TPU_SCHED_PERF_EN
      chk("perf_20", perf_run_cycles, 64'd20);
`else
      chk("perf_20", perf_run_cycles, 64'd0);
`endif
      cyc(1'b0, 64'h0, 1'b0, 1'b1, 1'b0, "perf_done_m");

      // Random traffic against the model
      do_reset("rand");
      for (int i = 0; i < 3000; i++) begin
         cyc($urandom_range(0, 99) < 60, {$urandom, $urandom}, $urandom_range(0, 99) < 50,
             $urandom_range(0, 99) < 25, $urandom_range(0, 99) < 15, "rand");
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/tpu_cmd_scheduler.md
TPU_CMD_SCHEDULER -- requirements
Module: tpu_cmd_scheduler

Interface
REQ-001 The block SHALL have parameter QUEUE_DEPTH, default 4, power of two >=2: command FIFO entries.
REQ-002 The block SHALL have parameter CMD_WIDTH, default 64: command word width, passed through unmodified.
REQ-003 The block SHALL have ports (name, direction, width, meaning):
- clk  in  1  single clock; all state on rising edge.
- rst  in  1  asynchronous reset, active-low.
- host_cmd_valid  in  1  host command offered.
- host_cmd_data  in  CMD_WIDTH  host command word.
- host_cmd_ready  out  1  queue can accept.
- cu_cmd_valid  out  1  command offered to control unit.
- cu_cmd_data  out  CMD_WIDTH  queue head word.
- cu_cmd_ready  in  1  control unit accepts.
- cu_done_irq  in  1  control unit single-cycle completion pulse.
- irq_clear  in  1  clears sticky interrupt.
- irq_out  out  1  sticky completion interrupt.
- queue_level  out  $clog2(QUEUE_DEPTH)+1  queued entries.
- completed_count  out  16  completed commands.
- sched_busy  out  1  queue non-empty or state not IDLE.
- perf_run_cycles  out  32  cycles spent in RUN.

Function
REQ-004 Push occurs on a rising edge with host_cmd_valid && host_cmd_ready; host_cmd_ready SHALL equal (queue_level != QUEUE_DEPTH), combinational from registered count only.
REQ-005 The FIFO SHALL use wrap-around read/write pointers; a push and a pop in the same cycle SHALL leave queue_level unchanged and preserve order.
REQ-006 The FSM SHALL have states IDLE, ISSUE, RUN.
REQ-007 IDLE -> ISSUE on the edge where queue_level != 0; otherwise IDLE holds.
REQ-008 In ISSUE, cu_cmd_valid SHALL be 1 and cu_cmd_data SHALL equal the head entry, stable until handshake; on cu_cmd_valid && cu_cmd_ready the head SHALL pop and state SHALL go to RUN.
REQ-009 cu_cmd_valid SHALL be 0 in IDLE and RUN; cu_cmd_data SHALL be 0 when queue empty.
REQ-010 In RUN, on cu_done_irq: completed_count increments (wraps 0xFFFF->0), irq_out sets, state goes to ISSUE if queue_level != 0 (counted after any same-cycle push), else IDLE.
REQ-011 cu_done_irq outside RUN SHALL be ignored (no count, no irq).
REQ-012 Latency: command pushed at edge E into empty queue with FSM IDLE SHALL see cu_cmd_valid high after edge E+1.
REQ-013 irq_out SHALL clear on irq_clear; simultaneous set and irq_clear SHALL leave irq_out = 1.
REQ-014 sched_busy SHALL be 1 when queue_level != 0 or state != IDLE.
REQ-015 Host push while full SHALL not occur (ready low); queue contents unaffected.

Reset
REQ-016 When rst = 0, asynchronously: FSM IDLE, pointers and queue_level 0, completed_count 0, irq_out 0, perf_run_cycles 0, cu_cmd_valid 0, cu_cmd_data 0, sched_busy 0, host_cmd_ready 1 once reset is released.
REQ-017 Reset mid-operation SHALL discard all queued and in-flight commands; no irq SHALL be generated for them.

Configuration
REQ-018 With macro TPU_SCHED_PERF_EN defined, perf_run_cycles SHALL increment every cycle the FSM is in RUN, saturating at 0xFFFFFFFF, reset to 0.
REQ-019 Without TPU_SCHED_PERF_EN, perf_run_cycles SHALL be tied to 0 and no counter logic SHALL be built.

Verification
REQ-020 Single command: push 0x0123, cu_cmd_ready=1 -> cu_cmd_valid high after edge E+1 with data 0x0123; done pulse -> completed_count=1, irq_out=1, IDLE.
REQ-021 Fill: push 5 commands with cu_cmd_ready=0 -> host_cmd_ready low after 4 accepted, queue_level=4; 5th held until first pop.
REQ-022 Back-to-back: queue 3 commands, done each after 10 cycles -> RUN->ISSUE directly, issue order preserved, completed_count=3.
REQ-023 irq_clear coincident with cu_done_irq -> irq_out stays 1; next irq_clear alone -> 0.
REQ-024 Assert rst low during RUN with 2 queued -> queue_level=0, irq_out=0, cu_cmd_valid=0 immediately; later done pulse ignored.
REQ-025 With TPU_SCHED_PERF_EN, RUN held 20 cycles -> perf_run_cycles=20; without macro -> 0.
